// File: rtl/sw_job_arbiter.sv
// sw_job_arbiter: shares one SW_core alignment engine between NUM_REQ requesters.
// Grants jobs round-robin with one job in flight at a time. It latches the granted
// requester's sequences and lengths, runs the core's input and result handshakes, and
// returns the result only to the requester that owns the job.
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   req_*               per-requester job channel (valid/ready, packed payload slices)
//   rsp_*               result channel; rsp_valid is one-hot to the owner, data is shared
//   core_*              SW_core input (valid/ready) and result (valid/ready) channels
//   busy                high whenever a job is in flight
//   job_count           completed jobs, error jobs included, wraps at 16 bits
//
// Optional: define SW_ARB_TIMEOUT_EN to enable a watchdog that aborts a job after
// TIMEOUT_CYCLES cycles in ISSUE/BUSY, returning an error response.
module sw_job_arbiter #(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned REF_MAX_LENGTH  = 128,
  parameter int unsigned READ_MAX_LENGTH = 128,
  parameter int unsigned SCORE_BW        = 10,
  parameter int unsigned TIMEOUT_CYCLES  = 65535,
  localparam int unsigned RefSeqW  = 2 * REF_MAX_LENGTH,
  localparam int unsigned ReadSeqW = 2 * READ_MAX_LENGTH,
  localparam int unsigned RefLenW  = $clog2(REF_MAX_LENGTH) + 1,
  localparam int unsigned ReadLenW = $clog2(READ_MAX_LENGTH) + 1,
  localparam int unsigned ColW     = $clog2(REF_MAX_LENGTH),
  localparam int unsigned RowW     = $clog2(READ_MAX_LENGTH),
  localparam int unsigned IdxW     = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*RefSeqW-1:0]   req_sequence_ref,
  input  logic [NUM_REQ*ReadSeqW-1:0]  req_sequence_read,
  input  logic [NUM_REQ*RefLenW-1:0]   req_ref_length,
  input  logic [NUM_REQ*ReadLenW-1:0]  req_read_length,
  output logic [NUM_REQ-1:0]           rsp_valid,
  input  logic [NUM_REQ-1:0]           rsp_ready,
  output logic [SCORE_BW-1:0]          rsp_score,  // two's complement
  output logic [ColW-1:0]              rsp_column,
  output logic [RowW-1:0]              rsp_row,
  output logic                         rsp_error,
  output logic                         core_valid,
  input  logic                         core_ready,
  output logic [RefSeqW-1:0]           core_sequence_ref,
  output logic [ReadSeqW-1:0]          core_sequence_read,
  output logic [RefLenW-1:0]           core_ref_length,
  output logic [ReadLenW-1:0]          core_read_length,
  input  logic                         core_result_valid,
  output logic                         core_result_ready,
  input  logic [SCORE_BW-1:0]          core_score,
  input  logic [ColW-1:0]              core_column,
  input  logic [RowW-1:0]              core_row,
  output logic                         busy,
  output logic [15:0]                  job_count
);

  typedef enum logic [1:0] {StIdle, StIssue, StBusy, StReturn} state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     rr_ptr_q, owner_q;
  logic [RefSeqW-1:0]  ref_q;
  logic [ReadSeqW-1:0] read_q;
  logic [RefLenW-1:0]  ref_len_q;
  logic [ReadLenW-1:0] read_len_q;
  logic [SCORE_BW-1:0] score_q;
  logic [ColW-1:0]     col_q;
  logic [RowW-1:0]     row_q;
  logic                err_q;
  logic [15:0]         job_count_q;

  // Round-robin search starting at rr_ptr_q.
  logic            grant_found;
  logic [IdxW-1:0] grant_idx;
  always_comb begin
    int unsigned idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!grant_found && req_valid[IdxW'(idx)]) begin
        grant_found = 1'b1;
        grant_idx   = IdxW'(idx);
      end
    end
  end

  logic [RefLenW-1:0]  sel_ref_len;
  logic [ReadLenW-1:0] sel_read_len;
  logic                len_ok;
  assign sel_ref_len  = req_ref_length[int'(grant_idx)*RefLenW +: RefLenW];
  assign sel_read_len = req_read_length[int'(grant_idx)*ReadLenW +: ReadLenW];
  assign len_ok = (sel_ref_len != '0) && (32'(sel_ref_len) <= REF_MAX_LENGTH) &&
                  (sel_read_len != '0) && (32'(sel_read_len) <= READ_MAX_LENGTH);

  logic accept, result_hs, rsp_hs, timeout_hit;
  assign accept    = (state_q == StIdle) && grant_found;
  assign result_hs = (state_q == StBusy) && core_result_valid;
  assign rsp_hs    = (state_q == StReturn) && rsp_ready[owner_q];

`ifdef SW_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt_q;
  logic [16:0] tmo_next;
  assign tmo_next    = {1'b0, tmo_cnt_q} + 17'd1;
  assign timeout_hit = ((state_q == StIssue) || (state_q == StBusy)) &&
                       (tmo_next >= 17'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else if (accept) begin
      tmo_cnt_q <= '0;
    end else if ((state_q == StIssue) || (state_q == StBusy)) begin
      tmo_cnt_q <= tmo_next[15:0];
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next state. A real result wins over a watchdog expiry in the same cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = len_ok ? StIssue : StReturn;
      StIssue:  if (timeout_hit) state_d = StReturn;
                else if (core_ready) state_d = StBusy;
      StBusy:   if (result_hs || timeout_hit) state_d = StReturn;
      StReturn: if (rsp_hs) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs. On watchdog expiry core_result_ready pulses to drain a late result.
  always_comb begin
    req_ready         = '0;
    rsp_valid         = '0;
    core_valid        = 1'b0;
    core_result_ready = timeout_hit;
    busy              = (state_q != StIdle);
    unique case (state_q)
      StIdle:   if (grant_found) req_ready[grant_idx] = 1'b1;
      StIssue:  core_valid = 1'b1;
      StBusy:   core_result_ready = 1'b1;
      StReturn: rsp_valid[owner_q] = 1'b1;
      default: ;
    endcase
  end

  // Job payload, result and bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      ref_q       <= '0;
      read_q      <= '0;
      ref_len_q   <= '0;
      read_len_q  <= '0;
      score_q     <= '0;
      col_q       <= '0;
      row_q       <= '0;
      err_q       <= 1'b0;
      job_count_q <= '0;
    end else begin
      if (accept) begin
        owner_q    <= grant_idx;
        rr_ptr_q   <= (grant_idx == IdxW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        ref_q      <= req_sequence_ref[int'(grant_idx)*RefSeqW +: RefSeqW];
        read_q     <= req_sequence_read[int'(grant_idx)*ReadSeqW +: ReadSeqW];
        ref_len_q  <= sel_ref_len;
        read_len_q <= sel_read_len;
        if (!len_ok) begin
          score_q <= '0;
          col_q   <= '0;
          row_q   <= '0;
          err_q   <= 1'b1;
        end
      end
      if (result_hs) begin
        score_q <= core_score;
        col_q   <= core_column;
        row_q   <= core_row;
        err_q   <= 1'b0;
      end else if (timeout_hit) begin
        score_q <= '0;
        col_q   <= '0;
        row_q   <= '0;
        err_q   <= 1'b1;
      end
      if (rsp_hs) job_count_q <= job_count_q + 16'd1;
    end
  end

  assign core_sequence_ref  = ref_q;
  assign core_sequence_read = read_q;
  assign core_ref_length    = ref_len_q;
  assign core_read_length   = read_len_q;
  assign rsp_score          = score_q;
  assign rsp_column         = col_q;
  assign rsp_row            = row_q;
  assign rsp_error          = err_q;
  assign job_count          = job_count_q;

endmodule

// File: tb/tb_sw_job_arbiter.sv
module tb_sw_job_arbiter;
  localparam int N = 4, RML = 128, DML = 128, SBW = 10;
  localparam int RSW = 2 * RML, DSW = 2 * DML, RLW = 8, DLW = 8, CW = 7, RW = 7;

  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req_valid = '0, req_ready, rsp_valid, rsp_ready = '0;
  logic [N*RSW-1:0] req_sequence_ref = '0;
  logic [N*DSW-1:0] req_sequence_read = '0;
  logic [N*RLW-1:0] req_ref_length = '0;
  logic [N*DLW-1:0] req_read_length = '0;
  logic [SBW-1:0] rsp_score, core_score = '0;
  logic [CW-1:0] rsp_column, core_column = '0;
  logic [RW-1:0] rsp_row, core_row = '0;
  logic rsp_error, core_valid, core_ready = 1'b0, core_result_valid = 1'b0;
  logic core_result_ready, busy;
  logic [RSW-1:0] core_sequence_ref;
  logic [DSW-1:0] core_sequence_read;
  logic [RLW-1:0] core_ref_length;
  logic [DLW-1:0] core_read_length;
  logic [15:0] job_count;

  int compared = 0, mismatched = 0;
  int m_ptr = 0;           // reference round-robin pointer
  logic [15:0] m_jobs = '0; // reference completed-job count

  sw_job_arbiter #(
    .NUM_REQ(N), .REF_MAX_LENGTH(RML), .READ_MAX_LENGTH(DML), .SCORE_BW(SBW),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_sequence_ref(req_sequence_ref), .req_sequence_read(req_sequence_read),
    .req_ref_length(req_ref_length), .req_read_length(req_read_length),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_score(rsp_score),
    .rsp_column(rsp_column), .rsp_row(rsp_row), .rsp_error(rsp_error),
    .core_valid(core_valid), .core_ready(core_ready),
    .core_sequence_ref(core_sequence_ref), .core_sequence_read(core_sequence_read),
    .core_ref_length(core_ref_length), .core_read_length(core_read_length),
    .core_result_valid(core_result_valid), .core_result_ready(core_result_ready),
    .core_score(core_score), .core_column(core_column), .core_row(core_row),
    .busy(busy), .job_count(job_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    req_valid = '0; rsp_ready = '0; core_ready = 1'b0; core_result_valid = 1'b0;
    rst = 1'b1;
    tick; tick;
    rst = 1'b0;
    m_ptr = 0; m_jobs = '0;
  endtask

  task automatic rand_payloads;
    for (int i = 0; i < N * RSW; i += 32) req_sequence_ref[i +: 32] = $urandom;
    for (int i = 0; i < N * DSW; i += 32) req_sequence_read[i +: 32] = $urandom;
  endtask

  task automatic rand_lengths;
    for (int i = 0; i < N; i++) begin
      req_ref_length[i*RLW +: RLW]  = RLW'($urandom_range(1, RML));
      req_read_length[i*DLW +: DLW] = DLW'($urandom_range(1, DML));
    end
  endtask

  // First valid requester at or after the pointer, cyclically; -1 if none.
  function automatic int exp_grant(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  // Runs one job through the DUT while acting as the core and the owning requester.
  task automatic serve_one(input int issue_wait, input int res_lat, input int rsp_hold,
                           input logic [SBW-1:0] s, input logic [CW-1:0] c,
                           input logic [RW-1:0] r, input bit drop_valid);
    int g;
    logic [N-1:0] oh;
    logic [RSW-1:0] e_ref;
    logic [DSW-1:0] e_read;
    logic [RLW-1:0] e_rl;
    logic [DLW-1:0] e_dl;
    logic [SBW-1:0] e_s;
    logic [CW-1:0] e_c;
    logic [RW-1:0] e_r;
    bit e_err;
    #1;
    g = exp_grant(req_valid);
    if (g < 0) begin
      compared++; mismatched++;
      $display("FAIL serve_setup: no requester valid (mask %b)", req_valid);
      return;
    end
    oh = '0; oh[g] = 1'b1;
    compared++;
    if (req_ready !== oh) begin
      mismatched++; $display("FAIL grant: req_ready=%b expected %b", req_ready, oh);
    end
    e_ref = req_sequence_ref[g*RSW +: RSW];
    e_read = req_sequence_read[g*DSW +: DSW];
    e_rl = req_ref_length[g*RLW +: RLW];
    e_dl = req_read_length[g*DLW +: DLW];
    e_err = (e_rl == 0) || (e_rl > RML) || (e_dl == 0) || (e_dl > DML);
    tick;  // accept edge
    m_ptr = (g + 1) % N;
    if (drop_valid) req_valid[g] = 1'b0;
    rand_payloads;  // the latch must hold the accepted job regardless
    #1;
    if (e_err) begin
      e_s = '0; e_c = '0; e_r = '0;
    end else begin
      e_s = s; e_c = c; e_r = r;
      for (int w = 0; w < issue_wait; w++) begin
        compared++;
        if (core_valid !== 1'b1 || core_sequence_ref !== e_ref || req_ready !== '0) begin
          mismatched++;
          $display("FAIL issue_hold: core_valid=%b req_ready=%b ref_ok=%b at stall %0d",
                   core_valid, req_ready, core_sequence_ref === e_ref, w);
        end
        tick;
      end
      compared++;
      if (core_valid !== 1'b1 || core_sequence_ref !== e_ref || core_sequence_read !== e_read ||
          core_ref_length !== e_rl || core_read_length !== e_dl) begin
        mismatched++;
        $display("FAIL issue_payload: core_valid=%b lens %0d/%0d expected %0d/%0d",
                 core_valid, core_ref_length, core_read_length, e_rl, e_dl);
      end
      core_ready = 1'b1;
      tick;
      core_ready = 1'b0;
      #1;
      compared++;
      if (core_valid !== 1'b0 || core_result_ready !== 1'b1) begin
        mismatched++;
        $display("FAIL busy_entry: core_valid=%b core_result_ready=%b expected 0/1",
                 core_valid, core_result_ready);
      end
      for (int l = 0; l < res_lat; l++) begin
        core_score = SBW'($urandom);
        tick;
      end
      core_result_valid = 1'b1; core_score = s; core_column = c; core_row = r;
      tick;
      core_result_valid = 1'b0; core_score = SBW'($urandom);
      #1;
    end
    compared++;
    if (rsp_valid !== oh || rsp_error !== e_err || rsp_score !== e_s || rsp_column !== e_c ||
        rsp_row !== e_r || core_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL response: valid=%b err=%b s=%0d c=%0d r=%0d expected %b %b %0d %0d %0d",
               rsp_valid, rsp_error, rsp_score, rsp_column, rsp_row, oh, e_err, e_s, e_c, e_r);
    end
    if (rsp_hold > 0) rsp_ready = ~oh;
    for (int h = 0; h < rsp_hold; h++) begin
      tick;
      compared++;
      if (rsp_valid !== oh || req_ready !== '0 || rsp_score !== e_s || rsp_error !== e_err) begin
        mismatched++;
        $display("FAIL rsp_hold: rsp_valid=%b req_ready=%b score=%0d expected %b 0 %0d",
                 rsp_valid, req_ready, rsp_score, oh, e_s);
      end
    end
    rsp_ready = oh;
    tick;
    rsp_ready = '0;
    m_jobs = m_jobs + 16'd1;
    #1;
    compared++;
    if (job_count !== m_jobs || rsp_valid !== '0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL complete: job_count=%0d rsp_valid=%b busy=%b expected %0d 0 0",
               job_count, rsp_valid, busy, m_jobs);
    end
  endtask

  task automatic test_reset;
    do_reset;
    compared++;
    if (req_ready !== '0 || rsp_valid !== '0 || core_valid !== 1'b0 || core_result_ready !== 1'b0 ||
        busy !== 1'b0 || job_count !== 16'd0 || rsp_error !== 1'b0 || rsp_score !== '0 ||
        core_sequence_ref !== '0 || core_ref_length !== '0) begin
      mismatched++;
      $display("FAIL reset: req_ready=%b rsp_valid=%b core_valid=%b busy=%b job_count=%0d",
               req_ready, rsp_valid, core_valid, busy, job_count);
    end
  endtask

  task automatic test_single_job;
    rand_payloads;
    req_ref_length[2*RLW +: RLW] = 8'd128;
    req_read_length[2*DLW +: DLW] = 8'd128;
    req_valid = 4'b0100;
    serve_one(0, 500, 0, 10'd37, 7'd100, 7'd90, 1'b1);
  endtask

  task automatic test_round_robin;
    do_reset;
    rand_payloads; rand_lengths;
    req_valid = '1;
    for (int j = 0; j < 8; j++) begin
      serve_one($urandom_range(0, 2), $urandom_range(0, 3), 0, SBW'($urandom), CW'($urandom),
                RW'($urandom), 1'b0);
      compared++;
      if (m_ptr != (j + 1) % N) begin
        mismatched++; $display("FAIL rr_order: pointer %0d after job %0d", m_ptr, j);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_issue_stall;
    rand_lengths;
    req_valid = 4'b1000;
    serve_one(20, 1, 0, -10'sd5, 7'd3, 7'd4, 1'b1);
  endtask

  task automatic test_bad_length;
    rand_lengths;
    req_ref_length[1*RLW +: RLW] = 8'd0;
    req_valid = 4'b0010;
    serve_one(0, 0, 0, '0, '0, '0, 1'b1);
    req_ref_length[1*RLW +: RLW] = 8'd50;
    req_read_length[1*DLW +: DLW] = 8'd129;
    req_valid = 4'b0010;
    serve_one(0, 0, 0, '0, '0, '0, 1'b1);
  endtask

  task automatic test_rsp_hold;
    rand_lengths;
    req_valid = '1;
    serve_one(0, 2, 10, 10'd200, 7'd7, 7'd8, 1'b1);
    req_valid = '0;
  endtask

  task automatic test_reset_mid_busy;
    rand_lengths;
    req_valid = 4'b0001;
    tick;  // accept
    req_valid = '0;
    core_ready = 1'b1;
    tick;  // issue handshake, now BUSY
    core_ready = 1'b0;
    rst = 1'b1;
    tick;
    compared++;
    if (busy !== 1'b0 || core_valid !== 1'b0 || core_result_ready !== 1'b0 || rsp_valid !== '0 ||
        job_count !== 16'd0 || core_sequence_ref !== '0 || rsp_error !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_mid_busy: busy=%b core_rr=%b rsp_valid=%b job_count=%0d",
               busy, core_result_ready, rsp_valid, job_count);
    end
    rst = 1'b0;
    m_ptr = 0; m_jobs = '0;
    core_result_valid = 1'b1;
    tick;
    core_result_valid = 1'b0;
    tick;
    compared++;
    if (rsp_valid !== '0 || busy !== 1'b0) begin
      mismatched++; $display("FAIL abandoned_job: rsp_valid=%b busy=%b expected 0", rsp_valid, busy);
    end
  endtask

  task automatic test_random;
    for (int j = 0; j < 40; j++) begin
      rand_payloads; rand_lengths;
      if ($urandom_range(0, 5) == 0) begin
        int i;
        i = $urandom_range(0, N - 1);
        if ($urandom_range(0, 1) == 0)
          req_ref_length[i*RLW +: RLW] = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'd200;
        else
          req_read_length[i*DLW +: DLW] = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'd129;
      end
      req_valid = N'($urandom_range(1, (1 << N) - 1));
      serve_one($urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(0, 2), SBW'($urandom),
                CW'($urandom), RW'($urandom), 1'b1);
    end
    req_valid = '0;
  endtask

`ifdef SW_ARB_TIMEOUT_EN
  task automatic test_timeout;
    int k;
    do_reset;
    rand_lengths;
    req_valid = 4'b0100;
    tick;  // accept; this cycle is the first ISSUE cycle
    req_valid = '0;
    core_ready = 1'b1;
    k = 0;
    while (rsp_valid === '0 && k < 300) begin
      tick;
      core_ready = 1'b0;
      k++;
    end
    compared++;
    if (k != 100 || rsp_valid !== 4'b0100 || rsp_error !== 1'b1 || rsp_score !== '0) begin
      mismatched++;
      $display("FAIL timeout: response after %0d cycles err=%b valid=%b expected 100 1 0100",
               k, rsp_error, rsp_valid);
    end
    rsp_ready = 4'b0100;
    tick;
    rsp_ready = '0;
  endtask
`endif

  initial begin
    test_reset;
    test_single_job;
    test_round_robin;
    test_issue_stall;
    test_bad_length;
    test_rsp_hold;
    test_reset_mid_busy;
    test_random;
`ifdef SW_ARB_TIMEOUT_EN
    test_timeout;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sw_job_arbiter.md
Name: sw_job_arbiter

Overview:
- Shares one SW_core alignment engine between NUM_REQ independent requesters, such as multiple host-link wrappers or on-chip job sources.
- Accepts a job from one requester, latches its sequences and lengths, and runs the core's valid/ready handshake on both the input and result sides.
- Returns score, column and row only to the requester that owns the job.
- Grants are round-robin, with one job in flight at a time.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
REF_MAX_LENGTH, 128, max reference length in bases (2 bits/base)
READ_MAX_LENGTH, 128, max read length in bases
SCORE_BW, 10, signed alignment score width
TIMEOUT_CYCLES, 65535, watchdog limit (used only with SW_ARB_TIMEOUT_EN)

Ports:
clk  in  1  single clock
rst  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester job valid
req_ready  out  NUM_REQ  per-requester job accept (one-hot or zero)
req_sequence_ref  in  NUM_REQ*2*REF_MAX_LENGTH  packed ref sequences, requester i in slice i
req_sequence_read  in  NUM_REQ*2*READ_MAX_LENGTH  packed read sequences
req_ref_length  in  NUM_REQ*(clog2(REF_MAX_LENGTH)+1)  per-requester ref length
req_read_length  in  NUM_REQ*(clog2(READ_MAX_LENGTH)+1)  per-requester read length
rsp_valid  out  NUM_REQ  result valid, one-hot to the owner
rsp_ready  in  NUM_REQ  per-requester result accept
rsp_score  out  SCORE_BW  shared result score (signed)
rsp_column  out  clog2(REF_MAX_LENGTH)  shared result column
rsp_row  out  clog2(READ_MAX_LENGTH)  shared result row
rsp_error  out  1  result is invalid (bad length or timeout)
core_valid  out  1  to SW_core i_valid
core_ready  in  1  from SW_core o_ready
core_sequence_ref / core_sequence_read / core_ref_length / core_read_length  out  matching widths  latched job to the core
core_result_valid  in  1  from SW_core o_valid
core_result_ready  out  1  to SW_core i_ready
core_score / core_column / core_row  in  matching widths  core results
busy  out  1  high whenever state != S_IDLE
job_count  out  16  completed jobs, wraps at 65535 -> 0

Behaviour:
- Reset (sync, rst=1 at posedge):
  - state=S_IDLE, rr_ptr=0, owner=0.
  - All outputs 0; latched payloads and results 0; job_count=0.
  - Reset mid-job abandons the job without any response.
- FSM states: S_IDLE, S_ISSUE, S_BUSY, S_RETURN.
- S_IDLE, grant selection:
  - Grant g is the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - req_ready[g]=1 combinationally in the same cycle; all other req_ready bits are 0.
  - On the accept edge: latch slice g payload, owner<=g, rr_ptr<=(g+1) mod NUM_REQ.
- S_IDLE, length check on accept:
  - Valid lengths: ref_length in 1..REF_MAX_LENGTH and read_length in 1..READ_MAX_LENGTH.
  - Valid: go to S_ISSUE.
  - Invalid: go to S_RETURN with score/column/row=0 and rsp_error=1; the core is not touched.
- S_ISSUE:
  - core_valid=1, core_* driven from the latch (held stable).
  - Handshake when core_valid & core_ready in the same cycle; core_valid deasserts the next cycle and state goes to S_BUSY.
  - If core_ready is already high on the first ISSUE cycle, ISSUE lasts exactly 1 cycle.
- S_BUSY:
  - core_result_ready=1.
  - On core_result_valid: latch score/column/row, rsp_error=0, go to S_RETURN.
  - A core_result_valid seen outside S_BUSY is ignored; core_result_ready=0 there.
- S_RETURN:
  - rsp_valid[owner]=1; rsp_* held stable until rsp_ready[owner]=1.
  - On handshake: job_count++ (error jobs included), go to S_IDLE.
  - rsp_ready from non-owners is ignored.
- Minimum latency, accept to rsp_valid: 3 cycles (accept -> ISSUE -> BUSY with immediate result -> RETURN).
- Next grant: at the earliest, the cycle after the RETURN handshake; no accept while busy.
- Simultaneous requests: the round-robin pointer guarantees each requester waits at most NUM_REQ-1 jobs.
- req_sequence_* of non-granted requesters are never sampled.

Optional Feature:
SW_ARB_TIMEOUT_EN:
- Defined:
  - A 16-bit counter clears on entry to S_ISSUE and increments each cycle in S_ISSUE/S_BUSY.
  - On reaching TIMEOUT_CYCLES: go to S_RETURN with rsp_error=1 and score/column/row=0.
  - core_result_ready is pulsed 1 for that cycle to drain any late result.
- Undefined: no counter; ISSUE/BUSY wait indefinitely.

Test Plan:
- Single job from req 2 (ref_len 128, read_len 128); core returns score 37, col 100, row 90 after 500 cycles -> rsp_valid=4'b0100, score 37, col 100, row 90, rsp_error 0, job_count 1.
- All 4 req_valid held high, 8 jobs -> grant order 0,1,2,3,0,1,2,3; each response goes to the granted index only.
- core_ready held 0 for 20 cycles after issue -> core_valid high and core_sequence_ref stable for all 20 cycles; handshake on cycle 21.
- Req 1 ref_length 0 -> core_valid never asserts; rsp_valid[1]=1, rsp_error=1, score 0, within 2 cycles of accept.
- rsp_ready[owner] held 0 for 10 cycles while rsp_ready of other requesters is 1 -> rsp held, no new grant; assert rst mid-BUSY -> all outputs 0, state IDLE next cycle.
- SW_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=100, core never responds -> rsp_error=1 exactly 100 cycles after entering ISSUE.
